packet_collector: RTL and testbench
===================================

PACKET_COLLECTOR -- requirements
Module: packet_collector

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- PACKET_WIDTH, 26, packet bus width
- DATA_W, 9, payload field [8:0]
- SRC_W, 6, sender field [14:9], as {x[2:0], y[2:0]}
- PID_W, 10, packet-ID field [24:15]
- MESH_X, 3, mesh columns
- NUM_SRC, 9, tracked senders
- FIFO_DEPTH, 4, receive buffer entries (power of 2, >=2)
- CNT_W, 16, counter width
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; the ports are named clk and reset.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- PacketIn, in, PACKET_WIDTH, packet from router local port
- ReqUpStr, in, 1, router request; held until granted
- GntUpStr, out, 1, one-cycle grant pulse
- UpStrFull, out, 1, buffer full
- pop, in, 1, consumer dequeue
- out_valid, out, 1, head entry valid
- out_data, out, DATA_W, head payload
- out_src, out, SRC_W, head sender
- out_pid, out, PID_W, head packet ID
- stat_sel, in, clog2(NUM_SRC), per-sender counter select
- stat_count, out, CNT_W, packets received from the selected sender
- total_count, out, CNT_W, all packets received
- bad_src_count, out, CNT_W, packets with out-of-range sender
- cycle_count, out, CNT_W, free-running timestamp

Function
REQ-004 The handshake FSM SHALL have two states: WAIT_REQ and GRANT.
REQ-005 In WAIT_REQ, when ReqUpStr=1 and the FIFO count < FIFO_DEPTH, the block SHALL capture PacketIn into the FIFO on that edge, assert GntUpStr for exactly the next cycle, and enter GRANT.
REQ-006 In GRANT, the block SHALL deassert GntUpStr and return to WAIT_REQ unconditionally; a Req seen in GRANT SHALL be ignored, giving at most one acceptance per 2 cycles.
REQ-007 In WAIT_REQ with ReqUpStr=1 and the FIFO full, the block SHALL not capture, not grant and stay in WAIT_REQ.
REQ-008 UpStrFull SHALL equal (FIFO count == FIFO_DEPTH), taken from the registered count.
REQ-009 A pop in the same cycle as the full-check SHALL not enable the push; full is evaluated before the pop.
REQ-010 out_valid SHALL be (count != 0), and out_* SHALL show the head entry combinationally from registered storage.
REQ-011 pop when out_valid=0 SHALL be ignored; it SHALL not change pointers or count.
REQ-012 A push and pop in the same cycle with 0 < count < FIFO_DEPTH SHALL leave count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-013 On each accepted packet, total_count SHALL increment, saturating at 2^CNT_W-1.
REQ-014 Sender index SHALL be y*MESH_X+x. If x >= MESH_X or the index >= NUM_SRC, bad_src_count SHALL increment (saturating) and the packet SHALL still be buffered. Otherwise that sender's counter SHALL increment (saturating).
REQ-015 stat_count SHALL be the counter selected by stat_sel with no added latency; stat_sel >= NUM_SRC SHALL read 0.
REQ-016 cycle_count SHALL increment every cycle and wrap from 2^CNT_W-1 to 0.
REQ-017 Latency is 1 cycle from the capture edge to out_valid=1 and GntUpStr=1.

Reset
REQ-018 While reset=1 at a clk edge, the block SHALL set: state=WAIT_REQ; GntUpStr=0; UpStrFull=0; out_valid=0; all pointers, count and counters=0; cycle_count=0.
REQ-019 Reset asserted in GRANT or with a non-empty FIFO SHALL discard buffered packets, and the pending grant SHALL not appear.
REQ-020 Reset SHALL override every other input in the same cycle.

Structure
REQ-021 A shared package noc_pkg SHALL hold the packet field widths and offsets, the collector FSM state typedef (WAIT_REQ, GRANT), and the default mesh dimensions.
REQ-022 Buffering SHALL be one sub-module, collector_fifo (parametrised width and depth, push/pop/count/full/empty). The FSM and statistics SHALL stay in packet_collector.

Verification
REQ-023 Single packet: Req=1 with PacketIn={1'b0, PID=10'd5, src=6'b001_000, data=9'h1A5} -> Gnt=1 next cycle only; out_valid=1, out_pid=5, out_src=001_000, out_data=1A5; stat_sel=1 gives stat_count=1.
REQ-024 Fill: DEPTH=4, Req held high, no pop -> exactly 4 grants spaced 2 cycles apart; UpStrFull=1 after the 4th; Req still high yields no 5th grant until one pop.
REQ-025 Bad sender: src=6'b011_000 (x=3) -> bad_src_count=1, total_count=1, the packet is readable, and all per-sender counts stay 0.
REQ-026 Concurrent: count=2, accept and pop on the same edge -> count stays 2, and the head advances to the 2nd packet.
REQ-027 Reset mid-operation: 3 packets buffered, in GRANT, reset=1 for 1 cycle -> Gnt=0, out_valid=0, all counts 0, cycle_count=0 on the following cycle.
REQ-028 Saturation: CNT_W=4, 16 packets from src 000_000 -> stat_count=15 and total_count=15 (held); cycle_count wraps 15->0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared packet layout, mesh defaults and collector FSM state type for the NoC blocks.
package noc_pkg;

  localparam int PKT_WIDTH    = 26;
  localparam int PKT_DATA_W   = 9;
  localparam int PKT_DATA_OFF = 0;
  localparam int PKT_SRC_W    = 6;
  localparam int PKT_SRC_OFF  = PKT_DATA_OFF + PKT_DATA_W;
  localparam int PKT_PID_W    = 10;
  localparam int PKT_PID_OFF  = PKT_SRC_OFF + PKT_SRC_W;

  localparam int MESH_X_DEF   = 3;
  localparam int MESH_Y_DEF   = 3;
  localparam int NUM_SRC_DEF  = MESH_X_DEF * MESH_Y_DEF;

  typedef enum logic {
    WAIT_REQ = 1'b0,
    GRANT    = 1'b1
  } collector_state_t;

endpackage

// File: rtl/collector_fifo.sv
// Small circular receive buffer; the head entry is visible combinationally from storage.
module collector_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full and empty come from the registered count, so a same-cycle pop never frees room for a push.
  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign empty     = (count == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage needs no reset; only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/packet_collector.sv
// Router local-port sink: req/grant handshake, receive buffer and per-sender statistics.
module packet_collector
  import noc_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_WIDTH,
  parameter int DATA_W       = PKT_DATA_W,
  parameter int SRC_W        = PKT_SRC_W,
  parameter int PID_W        = PKT_PID_W,
  parameter int MESH_X       = MESH_X_DEF,
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PACKET_WIDTH-1:0]    PacketIn,
  input  logic                       ReqUpStr,
  output logic                       GntUpStr,
  output logic                       UpStrFull,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [SRC_W-1:0]           out_src,
  output logic [PID_W-1:0]           out_pid,
  input  logic [$clog2(NUM_SRC)-1:0] stat_sel,
  output logic [CNT_W-1:0]           stat_count,
  output logic [CNT_W-1:0]           total_count,
  output logic [CNT_W-1:0]           bad_src_count,
  output logic [CNT_W-1:0]           cycle_count
);

  localparam int SRC_OFF = DATA_W;
  localparam int PID_OFF = DATA_W + SRC_W;
  localparam int STORE_W = DATA_W + SRC_W + PID_W;
  localparam int COORD_W = SRC_W / 2;

  collector_state_t               state;
  logic                           accept;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [STORE_W-1:0]             head;
  logic [$clog2(FIFO_DEPTH):0]    unused_count;
  logic                           unused_pkt_bits;
  logic [COORD_W-1:0]             src_x;
  logic [COORD_W-1:0]             src_y;
  int                             src_idx;
  logic                           src_bad;
  logic [CNT_W-1:0]               src_cnt [NUM_SRC];

  // Bits above the packet-ID field carry nothing this block uses.
  assign unused_pkt_bits = ^PacketIn[PACKET_WIDTH-1:STORE_W];

  assign accept    = (state == WAIT_REQ) && ReqUpStr && !fifo_full;
  assign UpStrFull = fifo_full;
  assign out_valid = !fifo_empty;
  assign out_data  = head[DATA_W-1:0];
  assign out_src   = head[SRC_OFF +: SRC_W];
  assign out_pid   = head[PID_OFF +: PID_W];

  collector_fifo #(
    .WIDTH (STORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (PacketIn[STORE_W-1:0]),
    .pop       (pop),
    .head_data (head),
    .count     (unused_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sender field is {x, y}; the flat index is y*MESH_X+x and anything off the mesh is bad.
  assign src_x = PacketIn[SRC_OFF+SRC_W-1 -: COORD_W];
  assign src_y = PacketIn[SRC_OFF +: COORD_W];
  always_comb begin
    src_idx = int'(src_y) * MESH_X + int'(src_x);
    src_bad = (int'(src_x) >= MESH_X) || (src_idx >= NUM_SRC);
  end

  // Handshake: one acceptance, then a forced grant cycle during which requests are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT_REQ;
      GntUpStr <= 1'b0;
    end else if (state == WAIT_REQ) begin
      if (accept) begin
        state    <= GRANT;
        GntUpStr <= 1'b1;
      end
    end else begin
      state    <= WAIT_REQ;
      GntUpStr <= 1'b0;
    end
  end

  // Saturating packet statistics, updated on each acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      total_count   <= '0;
      bad_src_count <= '0;
      for (int i = 0; i < NUM_SRC; i++) src_cnt[i] <= '0;
    end else if (accept) begin
      if (total_count != '1) total_count <= total_count + 1'b1;
      if (src_bad) begin
        if (bad_src_count != '1) bad_src_count <= bad_src_count + 1'b1;
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (src_idx == i && src_cnt[i] != '1) src_cnt[i] <= src_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Free-running timestamp that wraps.
  always_ff @(posedge clk) begin
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 1'b1;
  end

  // Per-sender readout; selects beyond the tracked senders read zero.
  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (int'(stat_sel) == i) stat_count = src_cnt[i];
    end
  end

endmodule

// File: tb/tb_packet_collector.sv
// Directed self-checking bench for packet_collector (default build plus a 4-bit counter build).
module tb_packet_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic [25:0] PacketIn;
  logic        ReqUpStr;
  logic        GntUpStr;
  logic        UpStrFull;
  logic        pop;
  logic        out_valid;
  logic [8:0]  out_data;
  logic [5:0]  out_src;
  logic [9:0]  out_pid;
  logic [3:0]  stat_sel;
  logic [15:0] stat_count;
  logic [15:0] total_count;
  logic [15:0] bad_src_count;
  logic [15:0] cycle_count;

  logic        s_reset;
  logic [25:0] s_PacketIn;
  logic        s_ReqUpStr;
  logic        s_GntUpStr;
  logic        s_UpStrFull;
  logic        s_pop;
  logic        s_out_valid;
  logic [8:0]  s_out_data;
  logic [5:0]  s_out_src;
  logic [9:0]  s_out_pid;
  logic [3:0]  s_stat_sel;
  logic [3:0]  s_stat_count;
  logic [3:0]  s_total_count;
  logic [3:0]  s_bad_src_count;
  logic [3:0]  s_cycle_count;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  packet_collector dut (
    .clk (clk), .reset (reset), .PacketIn (PacketIn), .ReqUpStr (ReqUpStr),
    .GntUpStr (GntUpStr), .UpStrFull (UpStrFull), .pop (pop), .out_valid (out_valid),
    .out_data (out_data), .out_src (out_src), .out_pid (out_pid), .stat_sel (stat_sel),
    .stat_count (stat_count), .total_count (total_count), .bad_src_count (bad_src_count),
    .cycle_count (cycle_count)
  );

  packet_collector #(.CNT_W (4)) dut_sat (
    .clk (clk), .reset (s_reset), .PacketIn (s_PacketIn), .ReqUpStr (s_ReqUpStr),
    .GntUpStr (s_GntUpStr), .UpStrFull (s_UpStrFull), .pop (s_pop), .out_valid (s_out_valid),
    .out_data (s_out_data), .out_src (s_out_src), .out_pid (s_out_pid), .stat_sel (s_stat_sel),
    .stat_count (s_stat_count), .total_count (s_total_count), .bad_src_count (s_bad_src_count),
    .cycle_count (s_cycle_count)
  );

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] mk_pkt(input logic [9:0] pid, input logic [5:0] src, input logic [8:0] data);
    return {1'b0, pid, src, data};
  endfunction

  task automatic do_reset();
    reset = 1'b1; ReqUpStr = 1'b0; pop = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // One request accepted on the first edge, then the mandatory grant cycle.
  task automatic send(input logic [25:0] pkt);
    PacketIn = pkt; ReqUpStr = 1'b1;
    tick();
    ReqUpStr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; ReqUpStr = 1'b1; pop = 1'b1; PacketIn = mk_pkt(10'd9, 6'b001_000, 9'h055); stat_sel = 4'd1;
    tick(); tick();
    total_checks++; if (GntUpStr !== 1'b0) begin bad_checks++; $display("[TB] FAIL reset_gnt got=%0b want=0", GntUpStr); end
    total_checks++; if (UpStrFull !== 1'b0) begin bad_checks++; $display("[TB] FAIL reset_full got=%0b want=0", UpStrFull); end
    total_checks++; if (out_valid !== 1'b0) begin bad_checks++; $display("[TB] FAIL reset_valid got=%0b want=0", out_valid); end
    total_checks++; if (total_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL reset_total got=%0d want=0", total_count); end
    total_checks++; if (bad_src_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL reset_bad got=%0d want=0", bad_src_count); end
    total_checks++; if (stat_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL reset_stat got=%0d want=0", stat_count); end
    total_checks++; if (cycle_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL reset_cycle got=%0d want=0", cycle_count); end
    reset = 1'b0; ReqUpStr = 1'b0; pop = 1'b0;
    tick(); tick(); tick();
    total_checks++; if (cycle_count !== 16'd3) begin bad_checks++; $display("[TB] FAIL cycle_run got=%0d want=3", cycle_count); end
  endtask

  task automatic test_single();
    do_reset();
    PacketIn = mk_pkt(10'd5, 6'b001_000, 9'h1A5); stat_sel = 4'd1; ReqUpStr = 1'b1;
    tick();
    ReqUpStr = 1'b0;
    total_checks++; if (GntUpStr !== 1'b1) begin bad_checks++; $display("[TB] FAIL single_gnt got=%0b want=1", GntUpStr); end
    total_checks++; if (out_valid !== 1'b1) begin bad_checks++; $display("[TB] FAIL single_valid got=%0b want=1", out_valid); end
    total_checks++; if (out_pid !== 10'd5) begin bad_checks++; $display("[TB] FAIL single_pid got=%0d want=5", out_pid); end
    total_checks++; if (out_src !== 6'b001_000) begin bad_checks++; $display("[TB] FAIL single_src got=%b want=001000", out_src); end
    total_checks++; if (out_data !== 9'h1A5) begin bad_checks++; $display("[TB] FAIL single_data got=%h want=1a5", out_data); end
    total_checks++; if (stat_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL single_stat got=%0d want=1", stat_count); end
    total_checks++; if (total_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL single_total got=%0d want=1", total_count); end
    tick();
    total_checks++; if (GntUpStr !== 1'b0) begin bad_checks++; $display("[TB] FAIL single_gnt_drop got=%0b want=0", GntUpStr); end
    pop = 1'b1; tick(); pop = 1'b0;
    total_checks++; if (out_valid !== 1'b0) begin bad_checks++; $display("[TB] FAIL single_popped got=%0b want=0", out_valid); end
  endtask

  task automatic test_fill();
    logic [8:0] drain_exp [4];
    logic       exp_gnt;
    drain_exp[0] = 9'd3; drain_exp[1] = 9'd5; drain_exp[2] = 9'd7; drain_exp[3] = 9'd14;
    do_reset();
    ReqUpStr = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      PacketIn = mk_pkt(10'(i), 6'b000_000, 9'(i));
      tick();
      exp_gnt = (i == 1 || i == 3 || i == 5 || i == 7);
      total_checks++; if (GntUpStr !== exp_gnt) begin bad_checks++; $display("[TB] FAIL fill_gnt cycle=%0d got=%0b want=%0b", i, GntUpStr, exp_gnt); end
    end
    total_checks++; if (UpStrFull !== 1'b1) begin bad_checks++; $display("[TB] FAIL fill_full got=%0b want=1", UpStrFull); end
    total_checks++; if (out_data !== 9'd1) begin bad_checks++; $display("[TB] FAIL fill_head got=%0d want=1", out_data); end
    PacketIn = mk_pkt(10'd13, 6'b000_000, 9'd13); pop = 1'b1;
    tick();
    pop = 1'b0;
    total_checks++; if (GntUpStr !== 1'b0) begin bad_checks++; $display("[TB] FAIL fill_pop_nogrant got=%0b want=0", GntUpStr); end
    total_checks++; if (UpStrFull !== 1'b0) begin bad_checks++; $display("[TB] FAIL fill_pop_full got=%0b want=0", UpStrFull); end
    total_checks++; if (out_data !== 9'd3) begin bad_checks++; $display("[TB] FAIL fill_pop_head got=%0d want=3", out_data); end
    PacketIn = mk_pkt(10'd14, 6'b000_000, 9'd14);
    tick();
    ReqUpStr = 1'b0;
    total_checks++; if (GntUpStr !== 1'b1) begin bad_checks++; $display("[TB] FAIL fill_fifth_gnt got=%0b want=1", GntUpStr); end
    total_checks++; if (UpStrFull !== 1'b1) begin bad_checks++; $display("[TB] FAIL fill_refull got=%0b want=1", UpStrFull); end
    for (int k = 0; k < 4; k++) begin
      total_checks++; if (out_data !== drain_exp[k]) begin bad_checks++; $display("[TB] FAIL fill_order idx=%0d got=%0d want=%0d", k, out_data, drain_exp[k]); end
      pop = 1'b1; tick(); pop = 1'b0;
    end
    total_checks++; if (out_valid !== 1'b0) begin bad_checks++; $display("[TB] FAIL fill_drained got=%0b want=0", out_valid); end
    pop = 1'b1; tick(); pop = 1'b0;
    total_checks++; if (out_valid !== 1'b0 || UpStrFull !== 1'b0) begin bad_checks++; $display("[TB] FAIL empty_pop valid=%0b full=%0b want=0,0", out_valid, UpStrFull); end
  endtask

  task automatic test_bad_src();
    do_reset();
    send(mk_pkt(10'd7, 6'b011_000, 9'h0AA));
    total_checks++; if (bad_src_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL badsrc_bad got=%0d want=1", bad_src_count); end
    total_checks++; if (total_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL badsrc_total got=%0d want=1", total_count); end
    total_checks++; if (out_valid !== 1'b1 || out_src !== 6'b011_000 || out_data !== 9'h0AA) begin bad_checks++; $display("[TB] FAIL badsrc_head valid=%0b src=%b data=%h want 1,011000,0aa", out_valid, out_src, out_data); end
    for (int s = 0; s < 9; s++) begin
      stat_sel = 4'(s); #1;
      total_checks++; if (stat_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL badsrc_stat sel=%0d got=%0d want=0", s, stat_count); end
    end
  endtask

  task automatic test_senders();
    do_reset();
    send(mk_pkt(10'd1, 6'b010_010, 9'd1));
    send(mk_pkt(10'd2, 6'b000_011, 9'd2));
    send(mk_pkt(10'd3, 6'b001_001, 9'd3));
    stat_sel = 4'd8; #1;
    total_checks++; if (stat_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL senders_idx8 got=%0d want=1", stat_count); end
    stat_sel = 4'd4; #1;
    total_checks++; if (stat_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL senders_idx4 got=%0d want=1", stat_count); end
    stat_sel = 4'd0; #1;
    total_checks++; if (stat_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL senders_idx0 got=%0d want=0", stat_count); end
    stat_sel = 4'd9; #1;
    total_checks++; if (stat_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL senders_sel9 got=%0d want=0", stat_count); end
    stat_sel = 4'd15; #1;
    total_checks++; if (stat_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL senders_sel15 got=%0d want=0", stat_count); end
    total_checks++; if (bad_src_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL senders_bad got=%0d want=1", bad_src_count); end
    total_checks++; if (total_count !== 16'd3) begin bad_checks++; $display("[TB] FAIL senders_total got=%0d want=3", total_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(mk_pkt(10'd1, 6'b000_000, 9'h011));
    send(mk_pkt(10'd2, 6'b000_000, 9'h022));
    PacketIn = mk_pkt(10'd3, 6'b000_000, 9'h033); ReqUpStr = 1'b1; pop = 1'b1;
    tick();
    ReqUpStr = 1'b0; pop = 1'b0;
    total_checks++; if (GntUpStr !== 1'b1) begin bad_checks++; $display("[TB] FAIL b2b_gnt got=%0b want=1", GntUpStr); end
    total_checks++; if (out_data !== 9'h022) begin bad_checks++; $display("[TB] FAIL b2b_head got=%h want=022", out_data); end
    tick();
    pop = 1'b1; tick();
    total_checks++; if (out_valid !== 1'b1 || out_data !== 9'h033) begin bad_checks++; $display("[TB] FAIL b2b_second valid=%0b data=%h want 1,033", out_valid, out_data); end
    tick();
    pop = 1'b0;
    total_checks++; if (out_valid !== 1'b0) begin bad_checks++; $display("[TB] FAIL b2b_count2 got=%0b want=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(mk_pkt(10'd1, 6'b001_000, 9'd1));
    send(mk_pkt(10'd2, 6'b001_000, 9'd2));
    PacketIn = mk_pkt(10'd3, 6'b001_000, 9'd3); ReqUpStr = 1'b1;
    tick();
    total_checks++; if (GntUpStr !== 1'b1 || total_count !== 16'd3) begin bad_checks++; $display("[TB] FAIL mid_setup gnt=%0b total=%0d want 1,3", GntUpStr, total_count); end
    reset = 1'b1; pop = 1'b1;
    tick();
    reset = 1'b0; ReqUpStr = 1'b0; pop = 1'b0; stat_sel = 4'd1;
    total_checks++; if (GntUpStr !== 1'b0) begin bad_checks++; $display("[TB] FAIL mid_gnt got=%0b want=0", GntUpStr); end
    total_checks++; if (out_valid !== 1'b0 || UpStrFull !== 1'b0) begin bad_checks++; $display("[TB] FAIL mid_fifo valid=%0b full=%0b want 0,0", out_valid, UpStrFull); end
    total_checks++; if (total_count !== 16'd0 || stat_count !== 16'd0 || bad_src_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL mid_counts total=%0d stat=%0d bad=%0d want 0", total_count, stat_count, bad_src_count); end
    total_checks++; if (cycle_count !== 16'd0) begin bad_checks++; $display("[TB] FAIL mid_cycle got=%0d want=0", cycle_count); end
    tick();
    total_checks++; if (GntUpStr !== 1'b0 || out_valid !== 1'b0 || cycle_count !== 16'd1) begin bad_checks++; $display("[TB] FAIL mid_after gnt=%0b valid=%0b cycle=%0d want 0,0,1", GntUpStr, out_valid, cycle_count); end
  endtask

  task automatic test_saturation();
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    total_checks++; if (s_cycle_count !== 4'd0) begin bad_checks++; $display("[TB] FAIL sat_cycle_reset got=%0d want=0", s_cycle_count); end
    for (int i = 0; i < 15; i++) tick();
    total_checks++; if (s_cycle_count !== 4'd15) begin bad_checks++; $display("[TB] FAIL sat_cycle_max got=%0d want=15", s_cycle_count); end
    tick();
    total_checks++; if (s_cycle_count !== 4'd0) begin bad_checks++; $display("[TB] FAIL sat_cycle_wrap got=%0d want=0", s_cycle_count); end
    s_reset = 1'b1; tick(); s_reset = 1'b0;
    s_pop = 1'b1; s_stat_sel = 4'd0;
    for (int k = 1; k <= 16; k++) begin
      s_PacketIn = mk_pkt(10'(k), 6'b000_000, 9'(k)); s_ReqUpStr = 1'b1;
      tick();
      s_ReqUpStr = 1'b0;
      tick();
      if (k == 15) begin
        total_checks++; if (s_total_count !== 4'd15 || s_stat_count !== 4'd15) begin bad_checks++; $display("[TB] FAIL sat_reach total=%0d stat=%0d want 15,15", s_total_count, s_stat_count); end
      end
    end
    s_pop = 1'b0;
    total_checks++; if (s_stat_count !== 4'd15) begin bad_checks++; $display("[TB] FAIL sat_stat_hold got=%0d want=15", s_stat_count); end
    total_checks++; if (s_total_count !== 4'd15) begin bad_checks++; $display("[TB] FAIL sat_total_hold got=%0d want=15", s_total_count); end
    total_checks++; if (s_bad_src_count !== 4'd0) begin bad_checks++; $display("[TB] FAIL sat_bad got=%0d want=0", s_bad_src_count); end
  endtask

  initial begin
    reset = 1'b1; PacketIn = '0; ReqUpStr = 1'b0; pop = 1'b0; stat_sel = '0;
    s_reset = 1'b1; s_PacketIn = '0; s_ReqUpStr = 1'b0; s_pop = 1'b0; s_stat_sel = '0;
    test_reset();
    test_single();
    test_fill();
    test_bad_src();
    test_senders();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
